// File: rtl/eeg_pea_out_arb.sv
// eeg_pea_out_arb: round-robin arbiter serialising PE result words onto the ORAM write port.
// Tracks per-PE last-word flags to detect layer completion and reports idle/done.
module eeg_pea_out_arb #(
  parameter int PE_ROW      = 4,
  parameter int PE_COL      = 4,
  parameter int PE_OUT_DW   = 8,
  parameter int OMUX_ADD_AW = 8,
  parameter int ORAM_ADD_AW = 10,
  parameter int PE_NUM      = PE_ROW * PE_COL,
  parameter int PE_IDX_AW   = $clog2(PE_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          CFG_START,
  input  logic [ORAM_ADD_AW-1:0]        CFG_BASE,
  input  logic [PE_NUM-1:0]             CFG_PE_MSK,
  output logic                          IS_IDLE,
  output logic                          DONE,
  input  logic [PE_NUM-1:0]             PE_OUT_VLD,
  input  logic [PE_NUM-1:0]             PE_OUT_LST,
  output logic [PE_NUM-1:0]             PE_OUT_RDY,
  input  logic [PE_NUM*PE_OUT_DW-1:0]   PE_OUT_DAT,
  input  logic [PE_NUM*OMUX_ADD_AW-1:0] PE_OUT_ADD,
  output logic                          ORAM_VLD,
  input  logic                          ORAM_RDY,
  output logic [ORAM_ADD_AW-1:0]        ORAM_ADD,
  output logic [PE_IDX_AW-1:0]          ORAM_BNK,
  output logic [PE_OUT_DW-1:0]          ORAM_DAT
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t                 state_q, state_d;
  logic [ORAM_ADD_AW-1:0] base_q;
  logic [PE_NUM-1:0]      msk_q, done_q, done_d, elig;
  logic [PE_IDX_AW-1:0]   rr_q, rr_d, gnt_idx;
  logic                   found, gnt, can_load;
  logic [OMUX_ADD_AW-1:0] gnt_add;
  logic [PE_OUT_DW-1:0]   gnt_dat;
  logic                   vld_q;
  logic [ORAM_ADD_AW-1:0] add_q;
  logic [PE_IDX_AW-1:0]   bnk_q;
  logic [PE_OUT_DW-1:0]   dat_q;
  // Descending scan so the last hit is the one closest to the rr pointer.
  always_comb begin
    can_load = ~vld_q | ORAM_RDY;
    elig     = (state_q == S_RUN) ? (PE_OUT_VLD & msk_q & ~done_q) : '0;
    found    = 1'b0;
    gnt_idx  = '0;
    for (int i = PE_NUM - 1; i >= 0; i--) begin
      int j;
      j = int'(rr_q) + i;
      if (j >= PE_NUM) j = j - PE_NUM;
      if (elig[j]) begin
        found   = 1'b1;
        gnt_idx = PE_IDX_AW'(j);
      end
    end
    gnt        = found & can_load;
    PE_OUT_RDY = gnt ? (PE_NUM'(1) << gnt_idx) : '0;
    done_d     = done_q | (PE_OUT_RDY & PE_OUT_LST);
    gnt_add    = PE_OUT_ADD[gnt_idx*OMUX_ADD_AW +: OMUX_ADD_AW];
    gnt_dat    = PE_OUT_DAT[gnt_idx*PE_OUT_DW +: PE_OUT_DW];
    rr_d       = ~gnt ? rr_q : (gnt_idx == PE_IDX_AW'(PE_NUM - 1)) ? '0 : gnt_idx + 1'b1;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = CFG_START ? S_RUN : S_IDLE;
      S_RUN:   state_d = ~&done_d ? S_RUN : (~|msk_q ? S_DONE : S_DRAIN);
      S_DRAIN: state_d = can_load ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      msk_q   <= '0;
      done_q  <= '0;
      rr_q    <= '0;
      vld_q   <= 1'b0;
      add_q   <= '0;
      bnk_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (state_q == S_IDLE && CFG_START) begin
        base_q <= CFG_BASE;
        msk_q  <= CFG_PE_MSK;
        done_q <= ~CFG_PE_MSK;
      end else begin
        done_q <= done_d;
      end
      if (gnt) begin
        vld_q <= 1'b1;
        add_q <= base_q + ORAM_ADD_AW'(gnt_add);
        bnk_q <= gnt_idx;
        dat_q <= gnt_dat;
      end else if (ORAM_RDY) begin
        vld_q <= 1'b0;
      end
    end
  end
  assign IS_IDLE  = (state_q == S_IDLE);
  assign DONE     = (state_q == S_DONE);
  assign ORAM_VLD = vld_q;
  assign ORAM_ADD = add_q;
  assign ORAM_BNK = bnk_q;
  assign ORAM_DAT = dat_q;
endmodule

// File: tb/tb_eeg_pea_out_arb.sv
// tb_eeg_pea_out_arb: directed, table-driven and random checks of eeg_pea_out_arb
// against a cycle-level reference model built from the arbitration rules.
module tb_eeg_pea_out_arb;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start;
  logic [9:0]   cfg_base;
  logic [15:0]  cfg_msk;
  logic         is_idle, done;
  logic [15:0]  pe_vld, pe_lst, pe_rdy;
  logic [127:0] pe_dat, pe_add;
  logic         oram_vld, oram_rdy;
  logic [9:0]   oram_add;
  logic [3:0]   oram_bnk;
  logic [7:0]   oram_dat;

  eeg_pea_out_arb dut (
    .clk(clk), .rst_n(rst_n), .CFG_START(cfg_start), .CFG_BASE(cfg_base),
    .CFG_PE_MSK(cfg_msk), .IS_IDLE(is_idle), .DONE(done),
    .PE_OUT_VLD(pe_vld), .PE_OUT_LST(pe_lst), .PE_OUT_RDY(pe_rdy),
    .PE_OUT_DAT(pe_dat), .PE_OUT_ADD(pe_add), .ORAM_VLD(oram_vld),
    .ORAM_RDY(oram_rdy), .ORAM_ADD(oram_add), .ORAM_BNK(oram_bnk), .ORAM_DAT(oram_dat)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_phase, m_rr, cyc = 0, last_gnt_cyc, done_cyc;
  logic [15:0] m_done, m_msk;
  logic [9:0]  m_base, m_add;
  logic        m_vld;
  logic [3:0]  m_bnk;
  logic [7:0]  m_dat;
  logic [21:0] wr_q[$];

  typedef struct {
    logic [9:0] base;
    int         pe;
    logic [7:0] padd;
    logic [7:0] pdat;
    logic [9:0] exp_add;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_rr = 0; m_done = '0; m_msk = '0; m_base = '0;
    m_vld = 1'b0; m_add = '0; m_bnk = '0; m_dat = '0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_idle"}, 32'(is_idle), 32'd1);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_rdy"}, 32'(pe_rdy), 32'd0);
    chk({nm, "_vld"}, 32'(oram_vld), 32'd0);
    chk({nm, "_add"}, 32'(oram_add), 32'd0);
    chk({nm, "_bnk"}, 32'(oram_bnk), 32'd0);
    chk({nm, "_dat"}, 32'(oram_dat), 32'd0);
  endtask

  // One clock: compare DUT against the model at the negedge, then advance the model.
  task automatic cycle();
    int g;
    logic [15:0] er, nd;
    @(negedge clk);
    g = -1;
    if (m_phase == P_RUN && (!m_vld || oram_rdy))
      for (int o = 0; o < 16; o++) begin
        int k;
        k = (m_rr + o) % 16;
        if (g < 0 && pe_vld[k] && m_msk[k] && !m_done[k]) g = k;
      end
    er = (g >= 0) ? (16'd1 << g) : 16'd0;
    chk("pe_rdy", 32'(pe_rdy), 32'(er));
    chk("oram_vld", 32'(oram_vld), 32'(m_vld));
    if (m_vld) begin
      chk("oram_add", 32'(oram_add), 32'(m_add));
      chk("oram_bnk", 32'(oram_bnk), 32'(m_bnk));
      chk("oram_dat", 32'(oram_dat), 32'(m_dat));
    end
    chk("is_idle", 32'(is_idle), 32'(m_phase == P_IDLE));
    chk("done", 32'(done), 32'(m_phase == P_DONE));
    if (oram_vld && oram_rdy) wr_q.push_back({oram_bnk, oram_add, oram_dat});
    if (done) done_cyc = cyc;
    if (g >= 0) last_gnt_cyc = cyc;
    nd = m_done;
    if (g >= 0 && pe_lst[g]) nd[g] = 1'b1;
    case (m_phase)
      P_IDLE:  if (cfg_start) begin m_phase = P_RUN; m_base = cfg_base; m_msk = cfg_msk; nd = ~cfg_msk; end
      P_RUN:   if (&nd) m_phase = (m_msk == 0) ? P_DONE : P_DRAIN;
      P_DRAIN: if (!m_vld || oram_rdy) m_phase = P_DONE;
      default: m_phase = P_IDLE;
    endcase
    m_done = nd;
    if (g >= 0) begin
      m_vld = 1'b1;
      m_bnk = g[3:0];
      m_dat = pe_dat[g*8 +: 8];
      m_add = m_base + {2'b00, pe_add[g*8 +: 8]};
      m_rr  = (g + 1) % 16;
    end else if (oram_rdy) m_vld = 1'b0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] b, input logic [15:0] m);
    cfg_base = b; cfg_msk = m; cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
  endtask

  task automatic run_idle(input int lim);
    int n = 0;
    while (!is_idle && n < lim) begin cycle(); n++; end
    chk("idle_timeout", 32'(is_idle), 32'd1);
  endtask

  task automatic run_full();
    wr_q.delete();
    done_cyc = -1;
    for (int k = 0; k < 16; k++) begin
      pe_add[k*8 +: 8] = 8'(k);
      pe_dat[k*8 +: 8] = 8'(8'h10 + k);
    end
    pe_vld = 16'hFFFF; pe_lst = 16'hFFFF; oram_rdy = 1'b1;
    start(10'h100, 16'hFFFF);
    run_idle(60);
    chk("full_cnt", 32'(wr_q.size()), 32'd16);
    for (int k = 0; k < 16 && k < wr_q.size(); k++)
      chk("full_word", 32'(wr_q[k]), 32'({4'(k), 10'(10'h100 + k), 8'(8'h10 + k)}));
    chk("full_done_lat", 32'(done_cyc - last_gnt_cyc), 32'd2);
    chk("full_idle", 32'(is_idle), 32'd1);
  endtask

  initial begin
    int fair_exp[6];
    int wrap_exp[4];
    int n;
    fair_exp = '{2, 5, 2, 5, 2, 5};
    wrap_exp = '{15, 0, 15, 0};
    vt[0] = '{base: 10'h3F0, pe: 4,  padd: 8'h20, pdat: 8'hAB, exp_add: 10'h010};
    vt[1] = '{base: 10'h000, pe: 0,  padd: 8'hFF, pdat: 8'h01, exp_add: 10'h0FF};
    vt[2] = '{base: 10'h3FF, pe: 15, padd: 8'h01, pdat: 8'h5A, exp_add: 10'h000};
    vt[3] = '{base: 10'h200, pe: 9,  padd: 8'h80, pdat: 8'hC3, exp_add: 10'h280};
    rst_n = 1'b0; cfg_start = 1'b0; cfg_base = '0; cfg_msk = '0;
    pe_vld = '0; pe_lst = '0; pe_dat = '0; pe_add = '0; oram_rdy = 1'b0;
    model_reset();
    #12;
    chk_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_full();

    // Fairness between PEs 2 and 5, with a start pulse that must be ignored mid-run.
    wr_q.delete();
    pe_lst = '0; pe_vld = 16'h0024; oram_rdy = 1'b1;
    start(10'h000, 16'hFFFF);
    for (int i = 0; i < 7; i++) begin
      cfg_start = (i == 3); cfg_msk = 16'h0000;
      cycle();
    end
    cfg_start = 1'b0;
    chk("fair_cnt", 32'(wr_q.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < wr_q.size(); i++) chk("fair_bnk", 32'(wr_q[i][21:18]), 32'(fair_exp[i]));
    pe_vld = '0; cycle();
    wr_q.delete();
    pe_vld = 16'h8001;
    for (int i = 0; i < 5; i++) cycle();
    chk("wrap_cnt", 32'(wr_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) chk("wrap_bnk", 32'(wr_q[i][21:18]), 32'(wrap_exp[i]));
    pe_vld = 16'hFFFF; pe_lst = 16'hFFFF;
    run_idle(60);

    // Backpressure: word held stable, no grants, then drain and reload without a bubble.
    pe_vld = '0; pe_lst = '0;
    start(10'h100, 16'hFFFF);
    pe_vld = 16'h0080; pe_add[7*8 +: 8] = 8'h07; pe_dat[7*8 +: 8] = 8'h77; oram_rdy = 1'b0;
    cycle();
    pe_dat[7*8 +: 8] = 8'h78;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_vld", 32'(oram_vld), 32'd1);
      chk("bp_dat", 32'(oram_dat), 32'h77);
      chk("bp_add", 32'(oram_add), 32'h107);
      chk("bp_rdy", 32'(pe_rdy), 32'd0);
    end
    oram_rdy = 1'b1;
    cycle();
    chk("bp_nobubble_vld", 32'(oram_vld), 32'd1);
    chk("bp_nobubble_dat", 32'(oram_dat), 32'h78);
    pe_vld = 16'hFFFF; pe_lst = 16'hFFFF;
    run_idle(60);

    // Mask: PE 3 requests but is masked off.
    wr_q.delete();
    pe_vld = 16'h000B; pe_lst = 16'hFFFF;
    start(10'h000, 16'h0003);
    run_idle(40);
    chk("msk_cnt", 32'(wr_q.size()), 32'd2);
    n = 0;
    foreach (wr_q[i]) if (wr_q[i][21:18] == 4'd3) n++;
    chk("msk_pe3", 32'(n), 32'd0);
    wr_q.delete();
    done_cyc = -1;
    start(10'h000, 16'h0000);
    run_idle(10);
    chk("msk0_cnt", 32'(wr_q.size()), 32'd0);
    chk("msk0_done", 32'(done_cyc >= 0), 32'd1);

    // Table-driven address/bank/data vectors including address wrap.
    for (int v = 0; v < 4; v++) begin
      wr_q.delete();
      pe_vld = '0; pe_lst = '0;
      pe_vld[vt[v].pe] = 1'b1; pe_lst[vt[v].pe] = 1'b1;
      pe_add[vt[v].pe*8 +: 8] = vt[v].padd;
      pe_dat[vt[v].pe*8 +: 8] = vt[v].pdat;
      start(vt[v].base, 16'd1 << vt[v].pe);
      run_idle(20);
      chk("tbl_cnt", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) begin
        chk("tbl_add", 32'(wr_q[0][17:8]), 32'(vt[v].exp_add));
        chk("tbl_bnk", 32'(wr_q[0][21:18]), 32'(vt[v].pe));
        chk("tbl_dat", 32'(wr_q[0][7:0]), 32'(vt[v].pdat));
      end
    end

    // Random layers against the model.
    for (int l = 0; l < 4; l++) begin
      pe_vld = '0;
      start(10'($urandom_range(0, 1023)), 16'($urandom));
      n = 0;
      while (!is_idle && n < 3000) begin
        pe_vld   = 16'($urandom);
        pe_lst   = 16'($urandom & $urandom & $urandom);
        pe_dat   = {$urandom, $urandom, $urandom, $urandom};
        pe_add   = {$urandom, $urandom, $urandom, $urandom};
        oram_rdy = ($urandom_range(0, 3) != 0);
        cycle();
        n++;
      end
      chk("rand_idle", 32'(is_idle), 32'd1);
    end

    // Asynchronous reset with a pending word, then a clean layer.
    pe_vld = 16'hFFFF; pe_lst = '0; oram_rdy = 1'b0;
    start(10'h100, 16'hFFFF);
    for (int i = 0; i < 3; i++) cycle();
    chk("pre_rst_vld", 32'(oram_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_full();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
